// File: rtl/sel_a2f_if.sv
// Handshake/bus bundle between the TX packetiser and its sources/sink.
// master drives the sources and the FTDI full flag; slave is the packetiser.
interface sel_a2f_if #(
  parameter int FT_DATA_WIDTH = 32,
  parameter int IQ_PAIR_WIDTH = 24
);
  logic                     loopback;
  logic [IQ_PAIR_WIDTH-1:0] fifo_data_i;
  logic                     fifo_empty_i;
  logic                     fifo_enough_i;
  logic                     fifo_re_o;
  logic [FT_DATA_WIDTH-1:0] cpu_data_i;
  logic                     cpu_valid_i;
  logic                     cpu_re_o;
  logic [FT_DATA_WIDTH-1:0] data_o;
  logic                     we_o;
  logic                     full_i;

  modport master (
    output loopback, fifo_data_i, fifo_empty_i, fifo_enough_i,
           cpu_data_i, cpu_valid_i, full_i,
    input  fifo_re_o, cpu_re_o, data_o, we_o
  );

  modport slave (
    input  loopback, fifo_data_i, fifo_empty_i, fifo_enough_i,
           cpu_data_i, cpu_valid_i, full_i,
    output fifo_re_o, cpu_re_o, data_o, we_o
  );
endinterface

// File: rtl/sel_a2f.sv
// TX packetiser: frames IQ FIFO bursts and CPU messages into FTDI packets,
// arbitrating between them without interleaving; loopback streams raw IQ words.
module sel_a2f #(
  parameter int          FT_DATA_WIDTH    = 32,
  parameter int          IQ_PAIR_WIDTH    = 24,
  parameter int          QSTART_BIT_INDEX = 16,
  parameter logic [15:0] BURST_LEN        = 16'd256
) (
  input logic      clk_i,
  input logic      reset,
  sel_a2f_if.slave bus
);
  localparam int HALF = IQ_PAIR_WIDTH / 2;

  typedef enum logic [2:0] {IDLE, CPU_HDR, CPU_DATA, FIFO_HDR, FIFO_DATA} state_e;

  state_e                   state_q, state_d;
  logic [FT_DATA_WIDTH-1:0] data_q, data_d;
  logic                     we_q, we_d;
  logic [IQ_PAIR_WIDTH-1:0] skid_q, skid_d;
  logic                     skid_vld_q, skid_vld_d;
  logic                     pend_q, pend_d;
  logic [15:0]              cnt_q, cnt_d;
  logic [15:0]              rd_cnt_q, rd_cnt_d;
  logic                     prio_fifo_q, prio_fifo_d;
  logic                     out_rdy, fifo_src, fifo_take, rd_ok, rd_en, cpu_re;
  logic [IQ_PAIR_WIDTH-1:0] fifo_word;

  function automatic logic [FT_DATA_WIDTH-1:0] map_iq(input logic [IQ_PAIR_WIDTH-1:0] d);
    logic [FT_DATA_WIDTH-1:0] w;
    w = '0;
    w[QSTART_BIT_INDEX +: HALF] = d[IQ_PAIR_WIDTH-1:HALF];
    w[HALF-1:0]                 = d[HALF-1:0];
    return w;
  endfunction

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    we_d        = we_q;
    skid_d      = skid_q;
    skid_vld_d  = skid_vld_q;
    cnt_d       = cnt_q;
    rd_cnt_d    = rd_cnt_q;
    prio_fifo_d = prio_fifo_q;
    cpu_re      = 1'b0;
    rd_ok       = 1'b0;

    out_rdy   = !we_q || !bus.full_i;
    fifo_src  = (state_q == IDLE) || (state_q == FIFO_DATA);
    fifo_word = skid_vld_q ? skid_q : bus.fifo_data_i;
    fifo_take = out_rdy && fifo_src && (skid_vld_q || pend_q);

    if (out_rdy) we_d = 1'b0;
    if (fifo_take) begin
      data_d = map_iq(fifo_word);
      we_d   = 1'b1;
    end

    // Skid drains first; returning read data parks there only on a stall.
    if (skid_vld_q) begin
      if (fifo_take) skid_vld_d = 1'b0;
    end else if (pend_q && !fifo_take) begin
      skid_d     = bus.fifo_data_i;
      skid_vld_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        rd_ok = bus.loopback;
        if (!bus.loopback && !skid_vld_q && !pend_q) begin
          if (bus.cpu_valid_i && (!bus.fifo_enough_i || !prio_fifo_q)) begin
            state_d     = CPU_HDR;
            prio_fifo_d = 1'b1;
          end else if (bus.fifo_enough_i) begin
            state_d     = FIFO_HDR;
            prio_fifo_d = 1'b0;
            cnt_d       = BURST_LEN;
            rd_cnt_d    = BURST_LEN;
          end
        end
      end
      CPU_HDR: begin
        if (out_rdy && bus.cpu_valid_i) begin
          cpu_re  = 1'b1;
          data_d  = {1'b1, bus.cpu_data_i[FT_DATA_WIDTH-2:0]};
          we_d    = 1'b1;
          cnt_d   = {8'd0, bus.cpu_data_i[27:20]};
          state_d = (bus.cpu_data_i[27:20] == 8'd0) ? IDLE : CPU_DATA;
        end
      end
      CPU_DATA: begin
        if (out_rdy && bus.cpu_valid_i) begin
          cpu_re = 1'b1;
          data_d = bus.cpu_data_i;
          we_d   = 1'b1;
          cnt_d  = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      FIFO_HDR: begin
        rd_ok = (rd_cnt_q != 16'd0);
        if (out_rdy) begin
          data_d       = '0;
          data_d[15:0] = BURST_LEN;
          we_d         = 1'b1;
          state_d      = FIFO_DATA;
        end
      end
      FIFO_DATA: begin
        rd_ok = (rd_cnt_q != 16'd0);
        if (fifo_take) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A read is only issued when its data is guaranteed a landing slot.
    rd_en  = rd_ok && out_rdy && !skid_vld_d && !bus.fifo_empty_i;
    pend_d = rd_en;
    if (rd_en && (state_q != IDLE)) rd_cnt_d = rd_cnt_q - 16'd1;
  end

  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      data_q      <= '0;
      we_q        <= 1'b0;
      skid_q      <= '0;
      skid_vld_q  <= 1'b0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      rd_cnt_q    <= '0;
      prio_fifo_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      we_q        <= we_d;
      skid_q      <= skid_d;
      skid_vld_q  <= skid_vld_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      prio_fifo_q <= prio_fifo_d;
    end
  end

  assign bus.data_o    = data_q;
  assign bus.we_o      = we_q;
  assign bus.fifo_re_o = rd_en && !reset;
  assign bus.cpu_re_o  = cpu_re;
endmodule

// File: tb/tb_sel_a2f.sv
// Directed bench for sel_a2f: queue models of the IQ FIFO and CPU source,
// a log of accepted FTDI words, and table-driven expected sequences.
module tb_sel_a2f;
  logic clk_i = 1'b0;
  logic reset = 1'b1;
  always #5 clk_i = ~clk_i;

  sel_a2f_if #(.FT_DATA_WIDTH(32), .IQ_PAIR_WIDTH(24)) bus ();

  sel_a2f #(
    .FT_DATA_WIDTH(32), .IQ_PAIR_WIDTH(24), .QSTART_BIT_INDEX(16), .BURST_LEN(16'd4)
  ) dut (
    .clk_i(clk_i), .reset(reset), .bus(bus)
  );

  typedef struct { logic [31:0] w;  logic [31:0] exp; } cpu_vec_t;
  typedef struct { logic [23:0] iq; logic [31:0] exp; } iq_vec_t;

  cpu_vec_t    cv[7];
  iq_vec_t     iv[8];
  logic [23:0] fq[$];
  logic [31:0] cq[$];
  logic [31:0] oq[$];
  int          ocyc[$];
  logic [31:0] ex[$];
  int          checks = 0, fails = 0, cyc = 0, fre_cnt = 0, cre_cnt = 0, base;
  logic        s_fre, s_cre, stall_prev = 1'b0;
  logic [31:0] stall_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int k = 0;
    while (oq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    checks++;
    if (oq.size() < n) begin
      fails++;
      $display("FAIL %s timeout words=%0d required=%0d", name, oq.size(), n);
    end
  endtask

  task automatic cmp_log(input string name);
    chk({name, "_count"}, oq.size(), ex.size());
    for (int i = 0; i < ex.size(); i++)
      chk(name, (i < oq.size()) ? oq[i] : 32'hxxxx_xxxx, ex[i]);
  endtask

  // Source/sink model: sample strobes at negedge, update sources after posedge.
  always begin
    @(negedge clk_i);
    s_fre = bus.fifo_re_o;
    s_cre = bus.cpu_re_o;
    if (reset) stall_prev = 1'b0;
    else begin
      cyc++;
      if (s_fre) chk("re_while_empty", {31'd0, bus.fifo_empty_i}, 32'd0);
      if (stall_prev) chk("stall_hold", bus.data_o, stall_data);
      if (bus.we_o && !bus.full_i) begin
        oq.push_back(bus.data_o);
        ocyc.push_back(cyc);
      end
      stall_prev = bus.we_o && bus.full_i;
      stall_data = bus.data_o;
      if (s_fre) fre_cnt++;
      if (s_cre) cre_cnt++;
    end
    @(posedge clk_i);
    #2;
    if (s_fre && fq.size() > 0) bus.fifo_data_i = fq.pop_front();
    if (s_cre && cq.size() > 0) void'(cq.pop_front());
    bus.fifo_empty_i  = (fq.size() == 0);
    bus.fifo_enough_i = (fq.size() >= 4);
    bus.cpu_valid_i   = (cq.size() > 0);
    bus.cpu_data_i    = (cq.size() > 0) ? cq[0] : 32'd0;
  end

  initial begin
    cv[0] = '{32'h0030_0000, 32'h8030_0000};
    cv[1] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF};
    cv[2] = '{32'h0123_4567, 32'h0123_4567};
    cv[3] = '{32'hCAFE_F00D, 32'hCAFE_F00D};
    cv[4] = '{32'h0000_0005, 32'h8000_0005};
    cv[5] = '{32'h7010_0000, 32'hF010_0000};
    cv[6] = '{32'h8000_0001, 32'h8000_0001};
    iv[0] = '{24'hABC123, 32'h0ABC_0123};
    iv[1] = '{24'h000FFF, 32'h0000_0FFF};
    iv[2] = '{24'hFFF000, 32'h0FFF_0000};
    iv[3] = '{24'h555AAA, 32'h0555_0AAA};
    iv[4] = '{24'hFFFFFF, 32'h0FFF_0FFF};
    iv[5] = '{24'h000000, 32'h0000_0000};
    iv[6] = '{24'h123456, 32'h0123_0456};
    iv[7] = '{24'h800001, 32'h0800_0001};

    bus.loopback = 1'b0; bus.full_i = 1'b0;
    bus.fifo_data_i = '0; bus.fifo_empty_i = 1'b1; bus.fifo_enough_i = 1'b0;
    bus.cpu_data_i = '0; bus.cpu_valid_i = 1'b0;

    tick(2);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_we", {31'd0, bus.we_o}, 32'd0);
    chk("rst_fifo_re", {31'd0, bus.fifo_re_o}, 32'd0);
    chk("rst_cpu_re", {31'd0, bus.cpu_re_o}, 32'd0);
    reset = 1'b0;
    tick(1);

    // CPU messages, including len=0 and a data word with bit31 set
    oq.delete(); ocyc.delete(); ex.delete(); base = cre_cnt;
    foreach (cv[i]) begin cq.push_back(cv[i].w); ex.push_back(cv[i].exp); end
    wait_words(7, 100, "cpu_wait");
    tick(4);
    cmp_log("cpu_word");
    chk("cpu_back2back", (ocyc.size() >= 4) ? ocyc[3] - ocyc[0] : -1, 32'd3);
    chk("cpu_re_count", cre_cnt - base, 32'd7);

    // Two FIFO bursts from the mapping table
    oq.delete(); ex.delete(); base = fre_cnt;
    foreach (iv[i]) fq.push_back(iv[i].iq);
    for (int p = 0; p < 2; p++) begin
      ex.push_back(32'h0000_0004);
      for (int i = 0; i < 4; i++) ex.push_back(iv[p*4+i].exp);
    end
    wait_words(10, 200, "fifo_wait");
    tick(4);
    cmp_log("fifo_word");
    chk("fifo_re_count", fre_cnt - base, 32'd8);

    // FIFO burst with a 5-cycle stall then full_i toggling
    oq.delete(); ex.delete(); base = fre_cnt;
    ex.push_back(32'h0000_0004);
    for (int i = 0; i < 4; i++) begin fq.push_back(iv[i].iq); ex.push_back(iv[i].exp); end
    tick(3);
    bus.full_i = 1'b1;
    tick(5);
    for (int i = 0; i < 10; i++) begin bus.full_i = ~bus.full_i; tick(1); end
    bus.full_i = 1'b0;
    wait_words(5, 100, "stall_wait");
    tick(4);
    cmp_log("stall_word");
    chk("stall_re_count", fre_cnt - base, 32'd4);

    // Arbitration with both sources ready: CPU first after reset, then alternate
    reset = 1'b1; tick(1);
    fq.delete(); cq.delete(); reset = 1'b0; tick(1);
    oq.delete(); ex.delete();
    cq.push_back(32'h0010_0000); cq.push_back(32'h1111_1111);
    cq.push_back(32'h0010_0000); cq.push_back(32'h2222_2222);
    foreach (iv[i]) fq.push_back(iv[i].iq);
    ex.push_back(32'h8010_0000); ex.push_back(32'h1111_1111);
    ex.push_back(32'h0000_0004);
    for (int i = 0; i < 4; i++) ex.push_back(iv[i].exp);
    ex.push_back(32'h8010_0000); ex.push_back(32'h2222_2222);
    ex.push_back(32'h0000_0004);
    for (int i = 4; i < 8; i++) ex.push_back(iv[i].exp);
    wait_words(14, 300, "arb_wait");
    tick(4);
    cmp_log("arb_word");

    // Loopback: headerless mapped passthrough
    oq.delete(); ex.delete(); base = fre_cnt;
    bus.loopback = 1'b1;
    for (int i = 4; i < 7; i++) begin fq.push_back(iv[i].iq); ex.push_back(iv[i].exp); end
    wait_words(3, 100, "loop_wait");
    tick(5);
    cmp_log("loop_word");
    chk("loop_re_count", fre_cnt - base, 32'd3);
    bus.loopback = 1'b0;
    tick(2);

    // Reset mid-packet: CPU packet starved after one data word
    oq.delete(); ex.delete();
    cq.push_back(32'h0030_0000); cq.push_back(32'hAAAA_0001);
    wait_words(2, 100, "part_wait");
    tick(3);
    chk("no_bubble_count", oq.size(), 32'd2);
    reset = 1'b1;
    #1;
    chk("midrst_data", bus.data_o, 32'd0);
    chk("midrst_we", {31'd0, bus.we_o}, 32'd0);
    chk("midrst_fifo_re", {31'd0, bus.fifo_re_o}, 32'd0);
    chk("midrst_cpu_re", {31'd0, bus.cpu_re_o}, 32'd0);
    cq.delete(); fq.delete();
    tick(1);
    reset = 1'b0;
    oq.delete(); ex.delete();
    cq.push_back(32'h0000_0005); ex.push_back(32'h8000_0005);
    wait_words(1, 100, "resync_wait");
    tick(4);
    cmp_log("resync_word");

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
